// File: rtl/alu_src_b_stage.sv
// Registered operand-B selector: picks a source slot or the PC-increment constant,
// applies an immediate transform, and buffers results in a 2-entry valid/ready queue.
module alu_src_b_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned CONST_IDX = 1,
  parameter int unsigned CONST_VAL = 4,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned SHAMT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     sel_err,
  output logic [1:0]               count
);

  localparam int unsigned EXT_W = WIDTH - IMM_W;
  localparam int unsigned DEPTH = 2;

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic             head, head_n;
  logic             tail, tail_n;
  logic [1:0]       count_n;
  logic             push, pop;
  logic             sel_oor;
  logic [WIDTH-1:0] raw;
  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] xf;

  // Source selection and immediate transform, resolved before the value is stored
  always_comb begin
    raw     = '0;
    sel_oor = (32'(sel) >= NUM_SRC);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) raw = src_data[k*WIDTH +: WIDTH];
    end
    if (sel == SEL_W'(CONST_IDX)) raw = WIDTH'(CONST_VAL);
    if (sel_oor) raw = '0;
    imm  = raw[IMM_W-1:0];
    sext = {{EXT_W{imm[IMM_W-1]}}, imm};
    case (mode)
      2'b01:   xf = sext;
      2'b10:   xf = sext << SHAMT;
      2'b11:   xf = {{EXT_W{1'b0}}, imm};
      default: xf = raw;
    endcase
  end

  // Queue next-state: write at tail on push, advance head on pop
  always_comb begin
    push    = in_valid & in_ready;
    pop     = out_valid & out_ready;
    mem_n   = mem;
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    if (push) begin
      mem_n[tail] = xf;
      tail_n      = ~tail;
    end
    if (pop) head_n = ~head;
    case ({push, pop})
      2'b10:   count_n = count + 2'd1;
      2'b01:   count_n = count - 2'd1;
      default: count_n = count;
    endcase
  end

  // Handshake flags and out_data are registered from next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      sel_err   <= 1'b0;
    end else begin
      mem       <= mem_n;
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      in_ready  <= (count_n != 2'd2);
      out_valid <= (count_n != 2'd0);
      out_data  <= (count_n != 2'd0) ? mem_n[head_n] : '0;
      sel_err   <= push & sel_oor;
    end
  end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed bench for alu_src_b_stage with a scoreboard queue of expected operands.
module tb_alu_src_b_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    sel;
  logic [1:0]    mode;
  logic [NS*W-1:0] src_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          sel_err;
  logic [1:0]    count;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_m = 0;
  logic [W-1:0] sb[$];

  alu_src_b_stage #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(2), .CONST_IDX(1), .CONST_VAL(4),
                    .IMM_W(16), .SHAMT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .mode(mode), .src_data(src_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_err(sel_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score push/pop against the model, then check state after the edge
  task automatic cyc(input logic v, input logic [1:0] s, input logic [1:0] m,
                     input logic [W-1:0] exp, input logic ordy);
    logic acc, pp;
    in_valid  = v;
    sel       = s;
    mode      = m;
    out_ready = ordy;
    acc = v && (cnt_m != 2);
    pp  = ordy && (cnt_m != 0);
    if (pp) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(out_valid), 32'd0);
      else chk("pop_data", out_data, sb.pop_front());
    end
    if (acc) sb.push_back(exp);
    cnt_m = cnt_m + (acc ? 1 : 0) - (pp ? 1 : 0);
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(cnt_m));
    chk("in_ready", 32'(in_ready), 32'(cnt_m != 2));
    chk("out_valid", 32'(out_valid), 32'(cnt_m != 0));
    chk("sel_err", 32'(sel_err), 32'(acc && (s >= 2'd3)));
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    cnt_m = 0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((cnt_m != 0) && (guard < 8)) begin
      cyc(1'b0, 2'd0, 2'd0, '0, 1'b1);
      guard++;
    end
    chk("drain_empty", 32'(cnt_m), 32'd0);
  endtask

  initial begin
    logic [W-1:0] r;
    reset = 1'b1; in_valid = 1'b0; sel = '0; mode = '0; out_ready = 1'b0;
    src_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Constant slot, pass-through, single push with latency of one edge
    cyc(1'b1, 2'd1, 2'b00, 32'h4, 1'b0);
    chk("t1_out_data", out_data, 32'h4);
    drain();

    // Immediate transforms on slot 2
    src_data[2*W +: W] = 32'h0000_8001;
    cyc(1'b1, 2'd2, 2'b01, 32'hFFFF_8001, 1'b1);
    cyc(1'b1, 2'd2, 2'b10, 32'hFFFE_0004, 1'b1);
    cyc(1'b1, 2'd2, 2'b11, 32'h0000_8001, 1'b1);
    src_data[0 +: W] = 32'hDEAD_BEEF;
    cyc(1'b1, 2'd0, 2'b01, 32'hFFFF_BEEF, 1'b1);
    cyc(1'b1, 2'd0, 2'b11, 32'h0000_BEEF, 1'b1);
    cyc(1'b1, 2'd0, 2'b00, 32'hDEAD_BEEF, 1'b1);
    cyc(1'b1, 2'd1, 2'b10, 32'h0000_0010, 1'b1);
    drain();

    // Fill to full with the consumer stalled, then release
    src_data[0 +: W] = 32'h1111_1111;
    cyc(1'b1, 2'd0, 2'b00, 32'h1111_1111, 1'b0);
    src_data[0 +: W] = 32'h2222_2222;
    cyc(1'b1, 2'd0, 2'b00, 32'h2222_2222, 1'b0);
    src_data[0 +: W] = 32'h3333_3333;
    cyc(1'b1, 2'd0, 2'b00, 32'h3333_3333, 1'b0);
    chk("t3_full_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Steady push and pop at occupancy one
    src_data[0 +: W] = 32'hA5A5_0001;
    cyc(1'b1, 2'd0, 2'b00, 32'hA5A5_0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      src_data[0 +: W] = r;
      cyc(1'b1, 2'd0, 2'b00, r, 1'b1);
      chk("t4_out_prev_in", out_data, r);
    end
    drain();

    // Out-of-range selector yields zero and a single-cycle error pulse
    src_data = '1;
    cyc(1'b1, 2'd3, 2'b01, 32'h0, 1'b0);
    cyc(1'b0, 2'd3, 2'b00, 32'h0, 1'b0);
    drain();

    // Reset with a full queue discards contents
    cyc(1'b1, 2'd1, 2'b00, 32'h4, 1'b0);
    cyc(1'b1, 2'd1, 2'b11, 32'h4, 1'b0);
    chk("t6_full", 32'(count), 32'd2);
    do_reset();
    cyc(1'b0, 2'd0, 2'b00, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
